// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding,
// transaction owner encoding and the full-word byte-enable pattern.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/arb_grant.sv
// Grant selection between the fetch and load/store requesters.
// Default build: fixed data priority (MEM holds the older instruction).
// With MEM_ARB_RR_EN defined: round-robin, the requester that did not
// win the previous grant wins a tie.
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic grant_en,
    input  logic inst_req,
    input  logic data_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner,
`endif
    output logic grant_inst,
    output logic grant_data
);

    // Pick at most one winner whenever the arbiter is able to grant.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!grant_en) begin
            grant_inst = 1'b0;
            grant_data = 1'b0;
        end else if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
            if (last_owner == OWNER_DATA) begin
                grant_inst = 1'b1;
            end else begin
                grant_data = 1'b1;
            end
`else
            grant_data = 1'b1;
`endif
        end else begin
            grant_inst = inst_req;
            grant_data = data_req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the fetch (IF) and load/store
// (MEM) requesters with a single outstanding transaction.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration
// instead of fixed data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic [1:0]        state_r;
    logic              owner_r;
    logic              discard_r;
    logic              buf_wr_r;
    logic [3:0]        buf_sel_r;
    logic [ADDR_W-1:0] buf_addr_r;
    logic [DATA_W-1:0] buf_wdata_r;
    logic              inst_data_ok_r;
    logic              data_data_ok_r;
    logic [DATA_W-1:0] inst_rdata_r;
    logic [DATA_W-1:0] data_rdata_r;

    logic grant_en_s;
    logic grant_inst_s;
    logic grant_data_s;
    logic grant_any_s;
    logic in_addr_s;
    logic resp_s;
    logic inst_keep_s;

    // Grants are only possible from IDLE and never while reset is held,
    // so the combinational addr_ok outputs stay low during reset.
    assign grant_en_s  = (state_r == ST_IDLE) && rst;
    assign grant_any_s = grant_inst_s || grant_data_s;
    assign in_addr_s   = (state_r == ST_ADDR);
    assign resp_s      = (state_r == ST_WAIT) && mem_data_ok;
    // A flush arriving together with the response still kills the fetch.
    assign inst_keep_s = !(discard_r || flush);

`ifdef MEM_ARB_RR_EN
    logic last_owner_r;

    // Remember who won the most recent grant for round-robin tie-breaks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_r <= OWNER_DATA;
        end else if (grant_any_s) begin
            last_owner_r <= grant_data_s ? OWNER_DATA : OWNER_INST;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`endif

    arb_grant u_arb_grant (
        .grant_en   (grant_en_s),
        .inst_req   (inst_req),
        .data_req   (data_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner_r),
`endif
        .grant_inst (grant_inst_s),
        .grant_data (grant_data_s)
    );

    assign inst_addr_ok = grant_inst_s;
    assign data_addr_ok = grant_data_s;
    assign inst_data_ok = inst_data_ok_r;
    assign data_data_ok = data_data_ok_r;
    assign inst_rdata   = inst_rdata_r;
    assign data_rdata   = data_rdata_r;
    assign busy         = (state_r != ST_IDLE);

    // Transaction FSM and owner tracking: IDLE -> ADDR -> WAIT -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            owner_r <= OWNER_INST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_any_s) begin
                        state_r <= ST_ADDR;
                        owner_r <= grant_data_s ? OWNER_DATA : OWNER_INST;
                    end else begin
                        state_r <= ST_IDLE;
                        owner_r <= owner_r;
                    end
                end
                ST_ADDR: begin
                    state_r <= mem_addr_ok ? ST_WAIT : ST_ADDR;
                end
                ST_WAIT: begin
                    state_r <= mem_data_ok ? ST_IDLE : ST_WAIT;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Discard flag: a flushed fetch still completes on the bus but its
    // result is dropped; the flag clears whenever the arbiter is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            discard_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            discard_r <= grant_inst_s && flush;
        end else if ((owner_r == OWNER_INST) && flush) begin
            discard_r <= 1'b1;
        end else begin
            discard_r <= discard_r;
        end
    end

    // Request buffer: capture the winning request at grant time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_wr_r    <= 1'b0;
            buf_sel_r   <= 4'h0;
            buf_addr_r  <= {ADDR_W{1'b0}};
            buf_wdata_r <= {DATA_W{1'b0}};
        end else if (grant_data_s) begin
            buf_wr_r    <= data_wr;
            buf_sel_r   <= data_sel;
            buf_addr_r  <= data_addr;
            buf_wdata_r <= data_wdata;
        end else if (grant_inst_s) begin
            buf_wr_r    <= 1'b0;
            buf_sel_r   <= SEL_WORD;
            buf_addr_r  <= inst_addr;
            buf_wdata_r <= {DATA_W{1'b0}};
        end else begin
            buf_wr_r    <= buf_wr_r;
            buf_sel_r   <= buf_sel_r;
            buf_addr_r  <= buf_addr_r;
            buf_wdata_r <= buf_wdata_r;
        end
    end

    // Response routing: one-cycle pulse and read-data capture for the owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_data_ok_r <= 1'b0;
            data_data_ok_r <= 1'b0;
            inst_rdata_r   <= {DATA_W{1'b0}};
            data_rdata_r   <= {DATA_W{1'b0}};
        end else if (resp_s && (owner_r == OWNER_DATA)) begin
            inst_data_ok_r <= 1'b0;
            data_data_ok_r <= 1'b1;
            data_rdata_r   <= mem_rdata;
        end else if (resp_s && inst_keep_s) begin
            inst_data_ok_r <= 1'b1;
            data_data_ok_r <= 1'b0;
            inst_rdata_r   <= mem_rdata;
        end else begin
            inst_data_ok_r <= 1'b0;
            data_data_ok_r <= 1'b0;
        end
    end

    // Port drive: the buffered request is presented only in ADDR.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_sel   = 4'h0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (in_addr_s) begin
            mem_req   = 1'b1;
            mem_wr    = buf_wr_r;
            mem_sel   = buf_sel_r;
            mem_addr  = buf_addr_r;
            mem_wdata = buf_wdata_r;
        end else begin
            mem_req   = 1'b0;
            mem_wr    = 1'b0;
            mem_sel   = 4'h0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a
// transaction-level reference model checked on every cycle.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_sel;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_sel     (data_sel),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One outstanding transaction: "active" until the bus returns data,
    // "accepted" once the bus has taken the address.
    bit          m_active, m_acc, m_who_data, m_drop, m_last_data;
    bit          m_ipulse, m_dpulse, m_pgi, m_pgd;
    logic [31:0] m_ird, m_drd;
    bit          b_wr;
    logic [3:0]  b_sel;
    logic [31:0] b_addr, b_wdata;

    initial begin
        bit e_gi, e_gd, on_bus;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_iaok", inst_addr_ok, 0);
                check("rst_daok", data_addr_ok, 0);
                check("rst_idok", inst_data_ok, 0);
                check("rst_ddok", data_data_ok, 0);
                check("rst_ird", inst_rdata, 0);
                check("rst_drd", data_rdata, 0);
                check("rst_busy", busy, 0);
                check("rst_mreq", mem_req, 0);
                check("rst_maddr", mem_addr, 0);
                m_active = 0; m_acc = 0; m_who_data = 0; m_drop = 0; m_last_data = 1;
                m_ipulse = 0; m_dpulse = 0; m_pgi = 0; m_pgd = 0;
                m_ird = 0; m_drd = 0;
            end else begin
                e_gi = 0; e_gd = 0;
                if (!m_active) begin
                    if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
                        if (m_last_data) e_gi = 1; else e_gd = 1;
`else
                        e_gd = 1;
`endif
                    end else begin
                        e_gi = inst_req; e_gd = data_req;
                    end
                end
                on_bus = m_active && !m_acc;
                check("m_iaok", inst_addr_ok, e_gi);
                check("m_daok", data_addr_ok, e_gd);
                check("m_idok", inst_data_ok, m_ipulse);
                check("m_ddok", data_data_ok, m_dpulse);
                check("m_ird", inst_rdata, m_ird);
                check("m_drd", data_rdata, m_drd);
                check("m_busy", busy, m_active);
                check("m_mreq", mem_req, on_bus);
                check("m_mwr", mem_wr, on_bus ? b_wr : 1'b0);
                check("m_msel", mem_sel, on_bus ? b_sel : 4'h0);
                check("m_maddr", mem_addr, on_bus ? b_addr : 32'h0);
                check("m_mwdata", mem_wdata, on_bus ? b_wdata : 32'h0);
                // advance to the next cycle
                m_ipulse = 0; m_dpulse = 0; m_pgi = e_gi; m_pgd = e_gd;
                if (e_gi || e_gd) begin
                    m_active = 1; m_acc = 0; m_who_data = e_gd; m_last_data = e_gd;
                    m_drop = e_gi && flush;
                    b_wr    = e_gd ? data_wr : 1'b0;
                    b_sel   = e_gd ? data_sel : 4'hF;
                    b_addr  = e_gd ? data_addr : inst_addr;
                    b_wdata = e_gd ? data_wdata : 32'h0;
                end else if (m_active) begin
                    if (!m_who_data && flush) m_drop = 1;
                    if (!m_acc) begin
                        if (mem_addr_ok) m_acc = 1;
                    end else if (mem_data_ok) begin
                        m_active = 0;
                        if (m_who_data) begin
                            m_dpulse = 1; m_drd = mem_rdata;
                        end else if (!m_drop) begin
                            m_ipulse = 1; m_ird = mem_rdata;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic bus_is(input string tag, input bit is_data);
        check({tag, "_mreq"}, mem_req, 1);
        check({tag, "_maddr"}, mem_addr, is_data ? 32'h80000010 : 32'hBFC00100);
        check({tag, "_mwr"}, mem_wr, is_data ? 1 : 0);
        check({tag, "_msel"}, mem_sel, is_data ? 4'b0011 : 4'hF);
        check({tag, "_mwdata"}, mem_wdata, is_data ? 32'h0000BEEF : 32'h0);
    endtask

    initial begin
        bit first_inst;
        rst = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_sel = 0; data_addr = 0; data_wdata = 0; flush = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        cyc(); cyc();
        #2;
        check("reset_busy", busy, 0);
        check("reset_mreq", mem_req, 0);
        rst = 1'b1;

        // B: simultaneous fetch and store straight after reset
`ifdef MEM_ARB_RR_EN
        first_inst = 1;
`else
        first_inst = 0;
`endif
        cyc();
        inst_req = 1; inst_addr = 32'hBFC00100;
        data_req = 1; data_wr = 1; data_sel = 4'b0011;
        data_addr = 32'h80000010; data_wdata = 32'h0000BEEF;
        #2;
        check("b_iaok1", inst_addr_ok, first_inst);
        check("b_daok1", data_addr_ok, !first_inst);
        cyc(); if (first_inst) inst_req = 0; else data_req = 0;
        #2; bus_is("b_bus1", !first_inst);
        cyc(); mem_addr_ok = 1;
        cyc(); mem_data_ok = 1; mem_rdata = first_inst ? 32'h11112222 : 32'h0;
        cyc(); #2;
        check("b_idok1", inst_data_ok, first_inst);
        check("b_ddok1", data_data_ok, !first_inst);
        check("b_iaok2", inst_addr_ok, !first_inst);
        check("b_daok2", data_addr_ok, first_inst);
        cyc(); inst_req = 0; data_req = 0;
        #2; bus_is("b_bus2", first_inst);
        cyc(); mem_addr_ok = 1;
        cyc(); mem_data_ok = 1; mem_rdata = first_inst ? 32'h0 : 32'h11112222;
        cyc(); #2;
        check("b_idok2", inst_data_ok, !first_inst);
        check("b_ddok2", data_data_ok, first_inst);
        check("b_ird", inst_rdata, 32'h11112222);
        data_wr = 0; data_sel = 4'hF;

        // A: single fetch, address accepted after one wait cycle
        cyc(); inst_req = 1; inst_addr = 32'hBFC00000;
        #2; check("a_iaok", inst_addr_ok, 1);
        cyc(); inst_req = 0;
        #2; check("a_maddr", mem_addr, 32'hBFC00000);
        check("a_msel", mem_sel, 4'hF);
        cyc(); mem_addr_ok = 1;
        cyc(); mem_data_ok = 1; mem_rdata = 32'h24010001;
        #2; check("a_idok_early", inst_data_ok, 0);
        cyc(); #2;
        check("a_idok", inst_data_ok, 1);
        check("a_ird", inst_rdata, 32'h24010001);
        check("a_busy", busy, 0);
        cyc(); #2; check("a_idok_once", inst_data_ok, 0);

        // C: flush while the fetch waits for data
        cyc(); inst_req = 1; inst_addr = 32'hBFC00300;
        cyc(); inst_req = 0; mem_addr_ok = 1;
        cyc(); flush = 1;
        cyc(); mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        cyc(); #2;
        check("c_idok", inst_data_ok, 0);
        check("c_ird", inst_rdata, 32'h24010001);
        check("c_busy", busy, 0);

        // D: slow bus, 5 cycles of address wait and 7 of data wait
        cyc(); data_req = 1; data_addr = 32'h80000020;
        for (int i = 0; i < 5; i++) begin
            cyc(); data_req = 0; #2;
            check("d_mreq", mem_req, 1);
            check("d_maddr", mem_addr, 32'h80000020);
            check("d_busy", busy, 1);
        end
        cyc(); mem_addr_ok = 1;
        for (int i = 0; i < 7; i++) begin
            cyc(); #2;
            check("d_wait_busy", busy, 1);
            check("d_wait_mreq", mem_req, 0);
        end
        cyc(); mem_data_ok = 1; mem_rdata = 32'hCAFEF00D;
        cyc(); #2;
        check("d_ddok", data_data_ok, 1);
        check("d_drd", data_rdata, 32'hCAFEF00D);

        // F: back-to-back loads on a one-cycle bus
        cyc(); data_req = 1; data_addr = 32'h80000000;
        #2; check("f_daok1", data_addr_ok, 1);
        cyc(); data_addr = 32'h80000004; mem_addr_ok = 1;
        #2; check("f_maddr1", mem_addr, 32'h80000000);
        cyc(); mem_data_ok = 1; mem_rdata = 32'hAAAA0000;
        #2; check("f_mreq_gap", mem_req, 0);
        cyc(); #2;
        check("f_ddok1", data_data_ok, 1);
        check("f_drd1", data_rdata, 32'hAAAA0000);
        check("f_daok2", data_addr_ok, 1);
        cyc(); data_req = 0; mem_addr_ok = 1;
        #2; check("f_maddr2", mem_addr, 32'h80000004);
        cyc(); mem_data_ok = 1; mem_rdata = 32'hBBBB0004;
        cyc(); #2;
        check("f_ddok2", data_data_ok, 1);
        check("f_drd2", data_rdata, 32'hBBBB0004);

        // E: reset while waiting for data, then a stray response
        cyc(); inst_req = 1; inst_addr = 32'hBFC00200;
        cyc(); inst_req = 0; mem_addr_ok = 1;
        cyc(); rst = 0;
        #2;
        check("e_busy", busy, 0);
        check("e_mreq", mem_req, 0);
        check("e_ird", inst_rdata, 0);
        check("e_drd", data_rdata, 0);
        cyc(); rst = 1; mem_data_ok = 1; mem_rdata = 32'hFFFFFFFF;
        cyc(); #2;
        check("e_idok", inst_data_ok, 0);
        check("e_ddok", data_data_ok, 0);
        check("e_busy2", busy, 0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = ((i % 600) != 599);
            if (inst_req && m_pgi) inst_req = 0;
            if (data_req && m_pgd) data_req = 0;
            if (!inst_req && $urandom_range(0, 3) == 0) begin
                inst_req = 1; inst_addr = $urandom & 32'hFFFFFFFC;
            end
            if (!data_req && $urandom_range(0, 3) == 0) begin
                data_req = 1; data_wr = 1'($urandom_range(0, 1));
                data_sel = 4'($urandom_range(0, 15));
                data_addr = $urandom; data_wdata = $urandom;
            end
            flush = ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
            if (m_active && !m_acc) mem_addr_ok = ($urandom_range(0, 2) == 0);
            else if (m_active && m_acc) mem_data_ok = ($urandom_range(0, 2) == 0);
        end
        cyc(); inst_req = 0; data_req = 0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
